atm_transaction: RTL

ATM_TRANSACTION -- requirements
Module: atm_transaction

---
 rtl/atm_transaction.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/atm_transaction.sv
// rtl/atm_transaction.sv - ATM session controller: card auth, balance ops, lockout and timeout.
module atm_transaction #(
  parameter int balance_width  = 20,
  parameter int max_tries      = 3,
  parameter int timeout_cycles = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     card_in,
  input  logic                     psw_submit,
  input  logic                     wrong_psw,
  input  logic [balance_width-1:0] balance,
  input  logic                     op_valid,
  input  logic [1:0]               op_code,
  input  logic [balance_width-1:0] amount,
  output logic [balance_width-1:0] updated_balance,
  output logic                     op_done,
  output logic [balance_width-1:0] display_balance,
  output logic [1:0]               err,
  output logic                     authed,
  output logic                     card_retained,
  output logic                     eject
);

  localparam int try_w = $clog2(max_tries + 1);
  localparam int tmo_w = $clog2(timeout_cycles + 1);

  typedef enum logic [2:0] {IDLE, AUTH, CHECK, MENU, EXEC, LOCKED} state_t;

  state_t                   state, next_state;
  logic [try_w-1:0]         try_cnt;
  logic [tmo_w-1:0]         idle_cnt;
  logic                     wait_remove;
  logic [1:0]               op_q;
  logic [balance_width-1:0] amt_q;
  logic [balance_width:0]   sum;
  logic [balance_width-1:0] exec_val;
  logic [1:0]               exec_err;
  logic                     last_try;
  logic                     timeout_hit;

  assign last_try      = (try_cnt == try_w'(max_tries - 1));
  assign timeout_hit   = (idle_cnt == tmo_w'(timeout_cycles - 1));
  assign sum           = {1'b0, balance} + {1'b0, amt_q};
  assign authed        = (state == MENU) || (state == EXEC);
  assign card_retained = (state == LOCKED);

  // Errors leave the balance untouched; the unchanged value is still written back.
  always_comb begin
    exec_val = balance;
    exec_err = 2'b00;
    case (op_q)
      2'b01: begin
        if (amt_q == '0)             exec_err = 2'b11;
        else if (sum[balance_width]) exec_err = 2'b10;
        else                         exec_val = sum[balance_width-1:0];
      end
      2'b10: begin
        if (amt_q == '0)         exec_err = 2'b11;
        else if (amt_q > balance) exec_err = 2'b01;
        else                      exec_val = balance - amt_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (card_in) next_state = AUTH;
      AUTH: begin
        if (!card_in)        next_state = IDLE;
        else if (psw_submit) next_state = CHECK;
      end
      CHECK: begin
        if (!card_in)       next_state = IDLE;
        else if (wrong_psw) next_state = last_try ? LOCKED : AUTH;
        else                next_state = MENU;
      end
      MENU: begin
        if (!card_in)                                         next_state = IDLE;
        else if (!wait_remove && op_valid && op_code != 2'b11) next_state = EXEC;
      end
      EXEC:    next_state = card_in ? MENU : IDLE;
      LOCKED:  next_state = LOCKED;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      try_cnt         <= '0;
      idle_cnt        <= '0;
      wait_remove     <= 1'b0;
      op_q            <= 2'b00;
      amt_q           <= '0;
      updated_balance <= '0;
      display_balance <= '0;
      err             <= 2'b00;
      op_done         <= 1'b0;
      eject           <= 1'b0;
    end else begin
      op_done <= 1'b0;
      eject   <= 1'b0;
      case (state)
        IDLE: begin
          wait_remove <= 1'b0;
          if (card_in) try_cnt <= '0;
        end
        CHECK: if (card_in) begin
          if (wrong_psw) begin
            try_cnt <= try_cnt + try_w'(1);
          end else begin
            updated_balance <= balance;
            display_balance <= balance;
            idle_cnt        <= '0;
            wait_remove     <= 1'b0;
          end
        end
        // After exit or timeout the session parks here until the card is pulled.
        MENU: if (card_in && !wait_remove) begin
          if (op_valid) begin
            err      <= 2'b00;
            idle_cnt <= '0;
            op_q     <= op_code;
            amt_q    <= amount;
            if (op_code == 2'b11) begin
              eject       <= 1'b1;
              wait_remove <= 1'b1;
            end
          end else if (timeout_hit) begin
            eject       <= 1'b1;
            wait_remove <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + tmo_w'(1);
          end
        end
        EXEC: if (card_in) begin
          op_done         <= 1'b1;
          updated_balance <= exec_val;
          display_balance <= exec_val;
          err             <= exec_err;
        end
        default: ;
      endcase
    end
  end

endmodule
